ifu_fetch: RTL

//  Instruction-fetch stage upstream of the RV32 execute core. Holds the fetch PC and issues

---
 rtl/ifu_pkg.sv | 23 ++
 rtl/ifu_fifo.sv | 67 ++++++
 rtl/ifu_fetch.sv | 115 +++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared types for the instruction-fetch stage: fetch FSM states, buffered entry
// layout and the NOP substituted for faulting fetches.
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous instruction buffer: DEPTH entries of {pc, inst, fault}, flush wins over
// push, head is read straight from storage with no push-to-head bypass.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             head_valid,
  output fetch_entry_t     head_entry
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;
  fetch_entry_t     mem_q [DEPTH];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; count gates validity, so stale words are never observed.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_entry;
  end

  assign count      = count_q;
  assign head_valid = (count_q != '0);
  assign head_entry = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: single-outstanding word fetches on a valid/ready bus,
// buffered in ifu_fifo, with redirect handling that discards wrong-path responses.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  input  logic        resp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int               CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic             kill_q, kill_d;
  logic             push, pop, flush, head_valid;
  logic [CNT_W-1:0] fifo_count, count_after;
  fetch_entry_t     push_entry, head_entry;

  assign flush       = redirect_valid;
  assign pop         = head_valid && inst_ready;
  assign push        = (state_q == WAIT) && resp_valid && !kill_q && !redirect_valid;
  assign count_after = flush ? '0 : fifo_count + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    push_entry.pc    = req_addr_q;
    push_entry.inst  = resp_err ? NOP_INST : resp_data;
    push_entry.fault = resp_err;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      kill_q     <= kill_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = redirect_valid ? align_pc(redirect_pc) : fetch_pc_q;
    kill_d     = kill_q;
    unique case (state_q)
      // A redirect flushes the buffer, so it can start the new path right away.
      IDLE: if (redirect_valid || fifo_count < DEPTH_C) state_d = REQ;
      REQ: begin
        // An address already on the bus stays up; kill marks its response as stale.
        if (redirect_valid) kill_d = 1'b1;
        if (req_ready) begin
          state_d = WAIT;
          if (!redirect_valid && !kill_q) fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      WAIT: begin
        if (resp_valid) begin
          kill_d  = 1'b0;
          state_d = (count_after < DEPTH_C) ? REQ : IDLE;
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    req_addr_d = (state_d == REQ && state_q != REQ) ? fetch_pc_d : req_addr_q;
  end

  always_comb begin
    req_valid  = (state_q == REQ);
    req_addr   = req_addr_q;
    inst_valid = head_valid;
    inst       = head_valid ? head_entry.inst  : '0;
    inst_pc    = head_valid ? head_entry.pc    : '0;
    inst_fault = head_valid ? head_entry.fault : 1'b0;
  end

  ifu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush),
    .count      (fifo_count),
    .head_valid (head_valid),
    .head_entry (head_entry)
  );

  a_resp_only_in_wait: assert property (@(posedge clock) disable iff (reset)
    resp_valid |-> state_q == WAIT)
    else $error("ifu_fetch: resp_valid with no request outstanding");

endmodule
